// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   ifq_state_t : fetch FSM states (IFQ_FETCH issues requests, IFQ_STALL waits for credit)
//   ifq_entry_t : one queue entry, {pc, instr}
package instr_fetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic {
        IFQ_FETCH = 1'b0,
        IFQ_STALL = 1'b1
    } ifq_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO of DEPTH {pc, instr} entries with push/pop/clear.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   push, wdata   write an entry (accepted when not full, or when popping)
//   pop,  rdata   remove the head entry; rdata always shows the head
//   clear         drop all entries (wins over push/pop)
//   count, full, empty  occupancy status
module instr_fetch_queue_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  ifq_entry_t    wdata,
    output ifq_entry_t    rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    ifq_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues sequential word fetches, queues returned
// words with their PCs and hands them to decode over valid/ready. A redirect
// flushes the queue and drops responses still in flight for the old path.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue responses reach decode in the same cycle).
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-low reset
//   mem_req/mem_addr/mem_gnt   fetch request channel
//   mem_rvalid/mem_rdata       in-order response channel
//   instr_valid/instr/instr_pc/instr_ready  decode handshake (queue head)
//   redirect/redirect_pc       flush and refetch from redirect_pc (low 2 bits ignored)
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    ifq_state_t      state;
    ifq_state_t      state_next;
    logic            mem_req_next;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] fetch_pc_next;
    logic [PC_W-1:0] resp_pc;
    logic [PC_W-1:0] resp_pc_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_next;
    logic [CW-1:0]   count_next;
    logic [SW-1:0]   credit_sum;

    logic            grant;
    logic            resp;
    logic            resp_keep;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    ifq_entry_t      fifo_wdata;
    ifq_entry_t      fifo_rdata;

    assign mem_addr   = fetch_pc;
    assign grant      = mem_req & mem_gnt;
    // Responses with nothing outstanding are spurious and ignored.
    assign resp       = mem_rvalid & (outstanding != '0);
    assign resp_keep  = resp & (discard == '0) & ~redirect;
    assign fifo_wdata = '{pc: resp_pc, instr: mem_rdata};
    assign fifo_pop   = ~fifo_empty & instr_ready & ~redirect;

`ifdef IFQ_BYPASS_EN
    // Empty queue: a fresh response is shown directly and skips the FIFO if taken.
    logic bypass;
    assign bypass      = resp_keep & fifo_empty;
    assign instr_valid = ~fifo_empty | bypass;
    assign instr       = fifo_empty ? mem_rdata : fifo_rdata.instr;
    assign instr_pc    = fifo_empty ? resp_pc : fifo_rdata.pc;
    assign fifo_push   = resp_keep & ~(bypass & instr_ready) & (~fifo_full | fifo_pop);
`else
    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_rdata.instr;
    assign instr_pc    = fifo_rdata.pc;
    assign fifo_push   = resp_keep & (~fifo_full | fifo_pop);
`endif

    instr_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ifq_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state: PCs, in-flight bookkeeping and credit-based request gating.
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        resp_pc_next     = resp_pc;
        discard_next     = discard;
        count_next       = fifo_count;
        outstanding_next = outstanding + CW'(grant) - CW'(resp);

        if (redirect) begin
            // Everything still in flight (including a same-cycle grant) is stale.
            count_next    = '0;
            discard_next  = outstanding_next;
            fetch_pc_next = redirect_pc & ~PC_W'(3);
            resp_pc_next  = redirect_pc & ~PC_W'(3);
        end else begin
            count_next   = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            discard_next = discard - CW'(resp && (discard != '0));
            if (grant) begin
                fetch_pc_next = fetch_pc + PC_STEP;
            end
            if (resp_keep) begin
                resp_pc_next = resp_pc + PC_STEP;
            end
        end

        // Queued plus in-flight words may never exceed the FIFO size.
        credit_sum = SW'(count_next) + SW'(outstanding_next);
        case (state)
            IFQ_FETCH: if (credit_sum >= SW'(DEPTH)) state_next = IFQ_STALL;
            IFQ_STALL: if (credit_sum <  SW'(DEPTH)) state_next = IFQ_FETCH;
            default:   state_next = IFQ_FETCH;
        endcase
        mem_req_next = (state_next == IFQ_FETCH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IFQ_FETCH;
            mem_req     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            mem_req     <= mem_req_next;
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

endmodule
